// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID latch, field decode, load-use hazard stall,
// 32x32 register file with write-through bypass, and the ID/EX pipeline register.
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        if_valid,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  output logic        stall_out,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_dest,
  output logic [5:0]  id_funct,
  output logic [31:0] id_imm,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data,
  output logic        id_regwrite,
  output logic        id_memread,
  output logic        id_memwrite,
  output logic        id_alusrc,
  output logic        id_illegal
);

  function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
    return 32'(v);
  endfunction

  logic        r_valid_p0;
  logic [31:0] r_instr_p0;
  logic [31:0] r_pc_p0;

  logic [31:0] r_rf [32];

  logic [5:0]  w_opc;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic        w_uses_rs;
  logic        w_uses_rt;
  logic        w_regwrite;
  logic        w_memread;
  logic        w_memwrite;
  logic        w_alusrc;
  logic        w_illegal;
  logic [4:0]  w_dest;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;
  logic signed [31:0] w_imm;
  logic        w_hazard;
  logic        w_bubble;

  logic        r_valid_p1;
  logic [31:0] r_pc_p1;
  logic [4:0]  r_rs_p1;
  logic [4:0]  r_rt_p1;
  logic [4:0]  r_dest_p1;
  logic [5:0]  r_funct_p1;
  logic [31:0] r_imm_p1;
  logic [31:0] r_rs_data_p1;
  logic [31:0] r_rt_data_p1;
  logic        r_regwrite_p1;
  logic        r_memread_p1;
  logic        r_memwrite_p1;
  logic        r_alusrc_p1;
  logic        r_illegal_p1;

  // ---- IF/ID boundary (p0) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_p0 <= 1'b0;
      r_instr_p0 <= '0;
      r_pc_p0    <= '0;
    end else if (flush) begin
      r_valid_p0 <= 1'b0;
      r_instr_p0 <= '0;
      r_pc_p0    <= '0;
    end else if (!stall_out) begin
      r_valid_p0 <= if_valid;
      r_instr_p0 <= if_instr;
      r_pc_p0    <= if_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  assign w_opc = r_instr_p0[31:26];
  assign w_rs  = r_instr_p0[25:21];
  assign w_rt  = r_instr_p0[20:16];
  assign w_rd  = r_instr_p0[15:11];
  assign w_imm = sext16(r_instr_p0[15:0]);

  always_comb begin
    w_uses_rs  = 1'b0;
    w_uses_rt  = 1'b0;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_alusrc   = 1'b0;
    w_illegal  = 1'b0;
    w_dest     = '0;
    case (w_opc)
      6'h00: begin
        w_uses_rs = 1'b1; w_uses_rt = 1'b1; w_regwrite = 1'b1; w_dest = w_rd;
      end
      6'h23: begin
        w_uses_rs = 1'b1; w_regwrite = 1'b1; w_memread = 1'b1;
        w_alusrc  = 1'b1; w_dest = w_rt;
      end
      6'h2B: begin
        w_uses_rs = 1'b1; w_uses_rt = 1'b1; w_memwrite = 1'b1; w_alusrc = 1'b1;
      end
      6'h08: begin
        w_uses_rs = 1'b1; w_regwrite = 1'b1; w_alusrc = 1'b1; w_dest = w_rt;
      end
      default: w_illegal = r_valid_p0;
    endcase
  end

  // r0 is hard-wired; a same-cycle write-back wins over the stored value.
  assign w_rs_data = (w_rs == 5'd0) ? 32'd0 :
                     (wb_we && wb_addr == w_rs) ? wb_data : r_rf[w_rs];
  assign w_rt_data = (w_rt == 5'd0) ? 32'd0 :
                     (wb_we && wb_addr == w_rt) ? wb_data : r_rf[w_rt];

  assign w_hazard  = (w_uses_rs && ex_rd == w_rs) || (w_uses_rt && ex_rd == w_rt);
  assign stall_out = r_valid_p0 && !flush && ex_memread && (ex_rd != 5'd0) && w_hazard;
  assign w_bubble  = flush || stall_out || !r_valid_p0;

  // ---- ID/EX boundary (p1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_bubble) begin
      r_valid_p1    <= 1'b0;
      r_pc_p1       <= '0;
      r_rs_p1       <= '0;
      r_rt_p1       <= '0;
      r_dest_p1     <= '0;
      r_funct_p1    <= '0;
      r_imm_p1      <= '0;
      r_rs_data_p1  <= '0;
      r_rt_data_p1  <= '0;
      r_regwrite_p1 <= 1'b0;
      r_memread_p1  <= 1'b0;
      r_memwrite_p1 <= 1'b0;
      r_alusrc_p1   <= 1'b0;
      r_illegal_p1  <= 1'b0;
    end else begin
      r_valid_p1    <= 1'b1;
      r_pc_p1       <= r_pc_p0;
      r_rs_p1       <= w_rs;
      r_rt_p1       <= w_rt;
      r_dest_p1     <= w_dest;
      r_funct_p1    <= r_instr_p0[5:0];
      r_imm_p1      <= w_imm;
      r_rs_data_p1  <= w_rs_data;
      r_rt_data_p1  <= w_rt_data;
      r_regwrite_p1 <= w_regwrite;
      r_memread_p1  <= w_memread;
      r_memwrite_p1 <= w_memwrite;
      r_alusrc_p1   <= w_alusrc;
      r_illegal_p1  <= w_illegal;
    end
  end

  assign id_valid    = r_valid_p1;
  assign id_pc       = r_pc_p1;
  assign id_rs       = r_rs_p1;
  assign id_rt       = r_rt_p1;
  assign id_dest     = r_dest_p1;
  assign id_funct    = r_funct_p1;
  assign id_imm      = r_imm_p1;
  assign id_rs_data  = r_rs_data_p1;
  assign id_rt_data  = r_rt_data_p1;
  assign id_regwrite = r_regwrite_p1;
  assign id_memread  = r_memread_p1;
  assign id_memwrite = r_memwrite_p1;
  assign id_alusrc   = r_alusrc_p1;
  assign id_illegal  = r_illegal_p1;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios with literal expectations, then random
// traffic compared every cycle against a table-driven behavioural model.
module tb_id_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] if_instr, if_pc, wb_data;
  logic        if_valid, flush, wb_we, ex_memread;
  logic [4:0]  wb_addr, ex_rd;
  logic        stall_out, id_valid, id_regwrite, id_memread, id_memwrite, id_alusrc, id_illegal;
  logic [31:0] id_pc, id_imm, id_rs_data, id_rt_data;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic [5:0]  id_funct;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .stall_out(stall_out),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_funct(id_funct), .id_imm(id_imm), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_alusrc(id_alusrc), .id_illegal(id_illegal)
  );

  int checks = 0;
  int errors = 0;

  // Model state: register file, IF/ID contents, expected ID/EX outputs.
  logic [31:0] m_rf [32];
  logic        m_v;
  logic [31:0] m_instr, m_pc;
  logic        e_valid, e_rw, e_mr, e_mw, e_as, e_il;
  logic [31:0] e_pc, e_imm, e_rsd, e_rtd;
  logic [4:0]  e_rs, e_rt, e_dest;
  logic [5:0]  e_funct;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {uses_rs, uses_rt, regwrite, memread, memwrite, alusrc, illegal, dest=rd, dest=rt}
  function automatic logic [8:0] ctl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b1_1_1_0_0_0_0_1_0;
      6'h23:   return 9'b1_0_1_1_0_1_0_0_1;
      6'h2B:   return 9'b1_1_0_0_1_1_0_0_0;
      6'h08:   return 9'b1_0_1_0_0_1_0_0_1;
      default: return 9'b0_0_0_0_0_0_1_0_0;
    endcase
  endfunction

  function automatic logic model_stall();
    logic [8:0] c;
    c = ctl(m_instr[31:26]);
    return m_v && !flush && ex_memread && ex_rd != 0 &&
           ((c[8] && ex_rd == m_instr[25:21]) || (c[7] && ex_rd == m_instr[20:16]));
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_v = 0; m_instr = '0; m_pc = '0;
    e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_as = 0; e_il = 0;
    e_pc = '0; e_imm = '0; e_rsd = '0; e_rtd = '0;
    e_rs = '0; e_rt = '0; e_dest = '0; e_funct = '0;
  endtask

  task automatic check_outputs();
    chk("id_valid", id_valid, e_valid);       chk("id_pc", id_pc, e_pc);
    chk("id_rs", id_rs, e_rs);                chk("id_rt", id_rt, e_rt);
    chk("id_dest", id_dest, e_dest);          chk("id_funct", id_funct, e_funct);
    chk("id_imm", id_imm, e_imm);             chk("id_rs_data", id_rs_data, e_rsd);
    chk("id_rt_data", id_rt_data, e_rtd);     chk("id_regwrite", id_regwrite, e_rw);
    chk("id_memread", id_memread, e_mr);      chk("id_memwrite", id_memwrite, e_mw);
    chk("id_alusrc", id_alusrc, e_as);        chk("id_illegal", id_illegal, e_il);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    logic st;
    logic [8:0] c;
    #1;
    st = model_stall();
    chk("stall_out", stall_out, st);
    c = ctl(m_instr[31:26]);
    if (flush || st || !m_v) begin
      e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_as = 0; e_il = 0;
      e_pc = '0; e_imm = '0; e_rsd = '0; e_rtd = '0;
      e_rs = '0; e_rt = '0; e_dest = '0; e_funct = '0;
    end else begin
      e_valid = 1; e_pc = m_pc;
      e_rs = m_instr[25:21]; e_rt = m_instr[20:16]; e_funct = m_instr[5:0];
      e_imm = {{16{m_instr[15]}}, m_instr[15:0]};
      e_rsd = operand(m_instr[25:21]); e_rtd = operand(m_instr[20:16]);
      e_rw = c[6]; e_mr = c[5]; e_mw = c[4]; e_as = c[3]; e_il = c[2];
      e_dest = c[1] ? m_instr[15:11] : (c[0] ? m_instr[20:16] : 5'd0);
    end
    if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
    if (flush) begin
      m_v = 0; m_instr = '0; m_pc = '0;
    end else if (!st) begin
      m_v = if_valid; m_instr = if_instr; m_pc = if_pc;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("stall_in_reset", stall_out, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  task automatic clear_inputs();
    if_instr = '0; if_pc = '0; if_valid = 0; flush = 0;
    wb_we = 0; wb_addr = '0; wb_data = '0; ex_memread = 0; ex_rd = '0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // r1=5, r2=7, then ADD r3,r1,r2
    wb_we = 1; wb_addr = 5'd1; wb_data = 32'd5; step();
    wb_addr = 5'd2; wb_data = 32'd7; step();
    wb_we = 0;
    if_instr = 32'h00221820; if_pc = 32'h100; if_valid = 1; step();
    if_valid = 0; if_instr = '0; step();
    chk("add_valid", id_valid, 1'b1);   chk("add_rs_data", id_rs_data, 32'd5);
    chk("add_rt_data", id_rt_data, 32'd7); chk("add_dest", id_dest, 5'd3);
    chk("add_regwrite", id_regwrite, 1'b1); chk("add_pc", id_pc, 32'h100);

    // load-use stall on rs=1
    if_instr = 32'h00221820; if_pc = 32'h104; if_valid = 1; step();
    ex_memread = 1; ex_rd = 5'd1; if_instr = 32'h00000000; if_pc = 32'h108;
    #1 chk("stall_lit", stall_out, 1'b1);
    step();
    chk("stall_bubble", id_valid, 1'b0);
    ex_memread = 0; if_valid = 0; step();
    chk("stall_issue_valid", id_valid, 1'b1); chk("stall_issue_pc", id_pc, 32'h104);

    // write-through bypass, then r0 write ignored
    if_instr = 32'h00802800; if_valid = 1; step();
    if_valid = 0; wb_we = 1; wb_addr = 5'd4; wb_data = 32'hDEADBEEF; step();
    chk("bypass_rs", id_rs_data, 32'hDEADBEEF);
    wb_addr = 5'd0; wb_data = 32'hFFFFFFFF; if_instr = 32'h00002800; if_valid = 1; step();
    wb_we = 0; if_valid = 0; step();
    chk("r0_zero", id_rs_data, 32'd0);

    // flush beats stall
    if_instr = 32'h00221820; if_valid = 1; step();
    if_valid = 0; ex_memread = 1; ex_rd = 5'd1; flush = 1;
    #1 chk("flush_stall", stall_out, 1'b0);
    step();
    chk("flush_bubble", id_valid, 1'b0);
    flush = 0; ex_memread = 0; step();
    chk("flush_cleared", id_valid, 1'b0);

    // illegal opcode and LW sign extension
    if_instr = 32'hFC000000; if_valid = 1; step();
    if_valid = 0; step();
    chk("ill_illegal", id_illegal, 1'b1); chk("ill_regwrite", id_regwrite, 1'b0);
    chk("ill_memread", id_memread, 1'b0); chk("ill_memwrite", id_memwrite, 1'b0);
    if_instr = 32'h8C22FFFC; if_valid = 1; step();
    if_valid = 0; step();
    chk("lw_imm", id_imm, 32'hFFFFFFFC); chk("lw_memread", id_memread, 1'b1);
    chk("lw_dest", id_dest, 5'd2);

    // reset in the middle of a stall
    if_instr = 32'h00221820; if_valid = 1; step();
    if_valid = 0; ex_memread = 1; ex_rd = 5'd1;
    #1 chk("pre_reset_stall", stall_out, 1'b1);
    do_reset();
    #1 chk("post_reset_stall", stall_out, 1'b0);
    step();
    chk("post_reset_valid", id_valid, 1'b0);
    ex_memread = 0; if_instr = 32'h00221820; if_valid = 1; step();
    if_valid = 0; step();
    chk("post_reset_rs", id_rs_data, 32'd0); chk("post_reset_rt", id_rt_data, 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 4))
          0: ins[31:26] = 6'h00;
          1: ins[31:26] = 6'h23;
          2: ins[31:26] = 6'h2B;
          3: ins[31:26] = 6'h08;
          default: ;
        endcase
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        if_instr   = ins;
        if_pc      = $urandom;
        if_valid   = ($urandom_range(0, 3) != 0);
        flush      = ($urandom_range(0, 9) == 0);
        wb_we      = ($urandom_range(0, 1) == 1);
        wb_addr    = 5'($urandom_range(0, 7));
        wb_data    = $urandom;
        ex_memread = ($urandom_range(0, 2) == 0);
        ex_rd      = 5'($urandom_range(0, 7));
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
